// File: rtl/sec32_pkg.sv
// Shared definitions for the 32-bit SEC code: widths, check-bit function and inject mask helper.
// The decoder bench reference model imports sec32_check from here as well.
package sec32_pkg;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int NGRP   = DATA_W / 4;
  localparam int INJ_W  = 6;
  localparam int CW_W   = DATA_W + CHK_W;
  localparam int FX_W   = 2 * CHK_W;

  // Nibble parities f and interleaved parities xe, packed as {xe, f}.
  function automatic logic [FX_W-1:0] sec32_fx(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] f, xe;
    for (int j = 0; j < NGRP; j++) f[j] = ^d[4*j +: 4];
    for (int k = 0; k < 4; k++) begin
      xe[k]   = d[k]    ^ d[k+4]  ^ d[k+8]  ^ d[k+12];
      xe[k+4] = d[k+16] ^ d[k+20] ^ d[k+24] ^ d[k+28];
    end
    return {xe, f};
  endfunction

  // Fold nibble parities into pair terms g and combine with xe; low half of xe pairs
  // with the upper-byte g terms and vice versa.
  function automatic logic [CHK_W-1:0] sec32_ic(input logic [CHK_W-1:0] f,
                                                input logic [CHK_W-1:0] xe);
    logic [CHK_W-1:0] g;
    g[0] = f[0] ^ f[1];
    g[1] = f[2] ^ f[3];
    g[2] = f[0] ^ f[2];
    g[3] = f[1] ^ f[3];
    g[4] = f[4] ^ f[5];
    g[5] = f[6] ^ f[7];
    g[6] = f[4] ^ f[6];
    g[7] = f[5] ^ f[7];
    return {xe[7:4] ^ g[3:0], xe[3:0] ^ g[7:4]};
  endfunction

  function automatic logic [CHK_W-1:0] sec32_check(input logic [DATA_W-1:0] d);
    logic [FX_W-1:0] fx;
    fx = sec32_fx(d);
    return sec32_ic(fx[CHK_W-1:0], fx[FX_W-1:CHK_W]);
  endfunction

  // One-hot flip mask over the {ic, d} codeword; positions 40-63 give an empty mask.
  function automatic logic [CW_W-1:0] sec32_flip(input logic [INJ_W-1:0] b);
    logic [CW_W-1:0] m;
    for (int i = 0; i < CW_W; i++) m[i] = (b == INJ_W'(i));
    return m;
  endfunction
endpackage

// File: rtl/sec32_pipe_stage.sv
// Payload + valid register with a stall enable; holds contents while en is low.
module sec32_pipe_stage #(
  parameter int W = 32
) (
  input  logic         Gclk,
  input  logic         Grst,
  input  logic         en,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d
);
  // Load on enable, clear on reset.
  always_ff @(posedge Gclk) begin
    if (Grst) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (en) begin
      out_v <= in_v;
      out_d <= in_d;
    end
  end
endmodule

// File: rtl/sec32_check_encoder.sv
// Two-stage SEC check-bit encoder with valid/ready on both sides and an accepted-word counter.
// Optional error injection enabled by defining SEC32_ERR_INJECT_EN.
module sec32_check_encoder
  import sec32_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit R_DRIVE = 1'b1
) (
  input  logic              Gclk,
  input  logic              Grst,
  input  logic              Gin_valid,
  output logic              Gin_ready,
  input  logic [DATA_W-1:0] Gin_data,
  output logic              Gout_valid,
  input  logic              Gout_ready,
  output logic [DATA_W-1:0] Gout_id,
  output logic [CHK_W-1:0]  Gout_ic,
  output logic              Gout_r,
  output logic [CNT_W-1:0]  Gword_cnt
`ifdef SEC32_ERR_INJECT_EN
  ,
  input  logic              Ginj_en,
  input  logic [INJ_W-1:0]  Ginj_bit
`endif
);
  localparam int STAGES = 2;

  logic [STAGES:0]          vld_pipe;
  logic                     adv1;
  logic [FX_W+DATA_W-1:0]   s1_q;
  logic [CW_W-1:0]          s2_d, s2_q, inj_mask;
  logic [CHK_W-1:0]         s1_ic;

  assign vld_pipe[0] = Gin_valid;
  // Stage 2 moves when empty or drained; stage 1 may also fill a bubble while stage 2 stalls.
  assign adv1      = ~vld_pipe[2] | Gout_ready;
  assign Gin_ready = ~vld_pipe[1] | adv1;

  sec32_pipe_stage #(.W(FX_W + DATA_W)) u_s1 (
    .Gclk  (Gclk),
    .Grst  (Grst),
    .en    (Gin_ready),
    .in_v  (vld_pipe[0]),
    .in_d  ({sec32_fx(Gin_data), Gin_data}),
    .out_v (vld_pipe[1]),
    .out_d (s1_q)
  );

  assign s1_ic = sec32_ic(s1_q[DATA_W +: CHK_W], s1_q[DATA_W+CHK_W +: CHK_W]);
  assign s2_d  = {s1_ic, s1_q[DATA_W-1:0]} ^ inj_mask;

  sec32_pipe_stage #(.W(CW_W)) u_s2 (
    .Gclk  (Gclk),
    .Grst  (Grst),
    .en    (adv1),
    .in_v  (vld_pipe[1]),
    .in_d  (s2_d),
    .out_v (vld_pipe[2]),
    .out_d (s2_q)
  );

`ifdef SEC32_ERR_INJECT_EN
  logic             inj_armed;
  logic [INJ_W-1:0] inj_bit;

  assign inj_mask = inj_armed ? sec32_flip(inj_bit) : '0;

  // Arm on request (latest request wins); disarm once a word has taken the flip into stage 2.
  always_ff @(posedge Gclk) begin
    if (Grst) begin
      inj_armed <= 1'b0;
      inj_bit   <= '0;
    end else if (Ginj_en) begin
      inj_armed <= 1'b1;
      inj_bit   <= Ginj_bit;
    end else if (vld_pipe[1] && adv1) begin
      inj_armed <= 1'b0;
    end
  end
`else
  assign inj_mask = '0;
`endif

  assign Gout_valid         = vld_pipe[2];
  assign {Gout_ic, Gout_id} = s2_q;
  assign Gout_r             = vld_pipe[2] ? R_DRIVE : 1'b0;

  // Count every input handshake, wrapping naturally.
  always_ff @(posedge Gclk) begin
    if (Grst) Gword_cnt <= '0;
    else if (Gin_valid && Gin_ready) Gword_cnt <= Gword_cnt + 1'b1;
  end
endmodule
